aclk_time_setter: RTL and testbench

Button-driven time/alarm setting controller: the initiator side of the aclock time-configuration interface. It captures the clock's current hours and minutes, lets the user edit the hour field and then the minute field with SET and INC buttons, and issues a single-cycle LD_time or LD_alarm pulse with stable BCD digits. It sits between the debounced front-panel buttons and the aclock core, and drives the core's H_in1/H_in0/M_in1/M_in0/LD_time/LD_alarm inputs.

---
 rtl/aclk_pkg.sv | 64 ++++++
 rtl/aclk_btn_edge.sv | 48 ++++
 rtl/aclk_time_setter.sv | 160 ++++++++++++++++
 tb/tb_aclk_time_setter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// Shared types and constants for the aclock time/alarm setter:
// setter state and field enums, BCD limits, digit widths and the
// BCD increment helpers used on the edit buffer.
package aclk_pkg;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int H1_W     = 2;
  localparam int DIGIT_W  = 4;

  localparam logic [H1_W-1:0]    HOUR_TENS_MAX    = H1_W'(HOUR_MAX / 10);
  localparam logic [DIGIT_W-1:0] HOUR_ONES_AT_MAX = DIGIT_W'(HOUR_MAX % 10);
  localparam logic [DIGIT_W-1:0] MIN_TENS_MAX     = DIGIT_W'(MIN_MAX / 10);
  localparam logic [DIGIT_W-1:0] ONES_MAX         = DIGIT_W'(MIN_MAX % 10);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EDIT_HOUR = 2'd1,
    ST_EDIT_MIN  = 2'd2,
    ST_COMMIT    = 2'd3
  } setter_state_e;

  typedef enum logic {
    FIELD_HOUR = 1'b0,
    FIELD_MIN  = 1'b1
  } field_e;

  typedef struct packed {
    logic [H1_W-1:0]    h1;
    logic [DIGIT_W-1:0] h0;
    logic [DIGIT_W-1:0] m1;
    logic [DIGIT_W-1:0] m0;
  } bcd_time_t;

  // Hour +1 in BCD, 23 wraps to 00; minutes untouched.
  function automatic bcd_time_t inc_hour(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.h1 == HOUR_TENS_MAX && t.h0 == HOUR_ONES_AT_MAX) begin
      r.h1 = '0;
      r.h0 = '0;
    end else if (t.h0 == ONES_MAX) begin
      r.h1 = t.h1 + 1'b1;
      r.h0 = '0;
    end else begin
      r.h0 = t.h0 + 1'b1;
    end
    return r;
  endfunction

  // Minute +1 in BCD, 59 wraps to 00; hours untouched (no carry out).
  function automatic bcd_time_t inc_min(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.m0 == ONES_MAX) begin
      r.m0 = '0;
      r.m1 = (t.m1 == MIN_TENS_MAX) ? '0 : t.m1 + 1'b1;
    end else begin
      r.m0 = t.m0 + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/aclk_btn_edge.sv
// Rising-edge detector for one debounced button. The previous level is
// registered; pulse is high in the cycle the button is first seen high.
// With REPEAT_EN set and en high, a button held HOLD_CYCLES edges after
// its rise gives one extra pulse, then one every REPEAT_CYCLES while held.
module aclk_btn_edge #(
  parameter bit REPEAT_EN     = 1'b0,
  parameter int HOLD_CYCLES   = 50,
  parameter int REPEAT_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic en,
  output logic pulse
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] HOLD_CNT   = CNT_W'(HOLD_CYCLES);
  // Reloading here makes the next compare hit exactly REPEAT_CYCLES later.
  localparam logic [CNT_W-1:0] RELOAD_CNT = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES + 1);

  logic             prev;
  logic [CNT_W-1:0] hold_cnt;
  logic             rise;
  logic             repeat_fire;

  assign rise        = btn & ~prev;
  assign repeat_fire = REPEAT_EN && en && btn && prev && (hold_cnt == HOLD_CNT);
  assign pulse       = rise | repeat_fire;

  // Track the previous level and count consecutive held cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      prev <= btn;
      if (!REPEAT_EN || !en || !btn) begin
        hold_cnt <= '0;
      end else if (repeat_fire) begin
        hold_cnt <= RELOAD_CNT;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/aclk_time_setter.sv
// Button-driven time/alarm setter for the aclock core. SET enters the
// hour edit, then the minute edit, then commits with a one-cycle
// LD_time or LD_alarm strobe; INC bumps the active field in BCD.
// Optional feature macro: AUTO_REPEAT_EN (INC auto-repeat while held).
module aclk_time_setter #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLD_CYCLES    = 50,
  parameter int REPEAT_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_alarm,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [3:0] M_out1,
  input  logic [3:0] M_out0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic       field_sel,
  output logic       target_alarm
);
  import aclk_pkg::*;

`ifdef AUTO_REPEAT_EN
  localparam bit INC_REPEAT = 1'b1;
`else
  localparam bit INC_REPEAT = 1'b0;
`endif

  localparam int TMO_W = 16;
  // Timer value seen on the edge that completes TIMEOUT_CYCLES idle edges.
  localparam logic [TMO_W-1:0] TIMEOUT_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  setter_state_e    state;
  field_e           field;
  bcd_time_t        buffer;
  bcd_time_t        shadow;
  logic [TMO_W-1:0] idle_cnt;
  logic             set_pulse;
  logic             inc_pulse;
  logic             in_edit;

  assign in_edit = (state == ST_EDIT_HOUR) || (state == ST_EDIT_MIN);

  aclk_btn_edge #(
    .REPEAT_EN     (1'b0),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_set_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_set),
    .en    (1'b0),
    .pulse (set_pulse)
  );

  aclk_btn_edge #(
    .REPEAT_EN     (INC_REPEAT),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_inc_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_inc),
    .en    (in_edit),
    .pulse (inc_pulse)
  );

  // Load digits are the edit buffer itself, so they stay stable around
  // the strobe and keep the committed value while idle.
  assign H_in1     = buffer.h1;
  assign H_in0     = buffer.h0;
  assign M_in1     = buffer.m1;
  assign M_in0     = buffer.m0;
  assign field_sel = field;

  // Setter FSM: SET takes priority over INC in the same cycle; any button
  // event in an edit state restarts the abandon timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      field        <= FIELD_HOUR;
      buffer       <= '0;
      shadow       <= '0;
      idle_cnt     <= '0;
      editing      <= 1'b0;
      target_alarm <= 1'b0;
      LD_time      <= 1'b0;
      LD_alarm     <= 1'b0;
    end else begin
      LD_time  <= 1'b0;
      LD_alarm <= 1'b0;
      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (set_pulse) begin
            state        <= ST_EDIT_HOUR;
            field        <= FIELD_HOUR;
            editing      <= 1'b1;
            target_alarm <= btn_alarm;
            buffer       <= btn_alarm ? shadow : {H_out1, H_out0, M_out1, M_out0};
          end
        end
        ST_EDIT_HOUR: begin
          if (set_pulse) begin
            state    <= ST_EDIT_MIN;
            field    <= FIELD_MIN;
            idle_cnt <= '0;
          end else if (inc_pulse) begin
            buffer   <= inc_hour(buffer);
            idle_cnt <= '0;
          end else if (idle_cnt == TIMEOUT_LAST) begin
            state    <= ST_IDLE;
            editing  <= 1'b0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_EDIT_MIN: begin
          if (set_pulse) begin
            state    <= ST_COMMIT;
            field    <= FIELD_HOUR;
            editing  <= 1'b0;
            idle_cnt <= '0;
            LD_time  <= ~target_alarm;
            LD_alarm <= target_alarm;
          end else if (inc_pulse) begin
            buffer   <= inc_min(buffer);
            idle_cnt <= '0;
          end else if (idle_cnt == TIMEOUT_LAST) begin
            state    <= ST_IDLE;
            field    <= FIELD_HOUR;
            editing  <= 1'b0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          if (target_alarm) begin
            shadow <= buffer;
          end
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aclk_time_setter.sv
// Bench for aclk_time_setter: scenario tasks with inline checks, and a
// scoreboard queue of expected load-strobe words ({LD_time, LD_alarm,
// H_in1, H_in0, M_in1, M_in0}) consumed when a strobe is captured.
module tb_aclk_time_setter;

  localparam int TIMEOUT = 1000;
  localparam int HOLD    = 50;
  localparam int REP     = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_set = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_alarm = 1'b0;
  logic [1:0] H_out1 = '0;
  logic [3:0] H_out0 = '0;
  logic [3:0] M_out1 = '0;
  logic [3:0] M_out0 = '0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, editing, field_sel, target_alarm;

  int compared = 0;
  int mismatched = 0;
  int strobe_cnt = 0;
  int model_h;
  int model_m;
  logic [15:0] exp_q[$];

  aclk_time_setter #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_set      (btn_set),
    .btn_inc      (btn_inc),
    .btn_alarm    (btn_alarm),
    .H_out1       (H_out1),
    .H_out0       (H_out0),
    .M_out1       (M_out1),
    .M_out0       (M_out0),
    .H_in1        (H_in1),
    .H_in0        (H_in0),
    .M_in1        (M_in1),
    .M_in0        (M_in0),
    .LD_time      (LD_time),
    .LD_alarm     (LD_alarm),
    .editing      (editing),
    .field_sel    (field_sel),
    .target_alarm (target_alarm)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Counts every cycle in which a strobe was high (sampled before update).
  always @(posedge clk) begin
    if (LD_time || LD_alarm) strobe_cnt++;
  end

  function automatic logic [15:0] exp_word(input bit lt, input bit la, input int h, input int m);
    return {lt, la, 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [13:0] exp_digits(input int h, input int m);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] obs_word();
    return {LD_time, LD_alarm, H_in1, H_in0, M_in1, M_in0};
  endfunction

  function automatic logic [13:0] obs_digits();
    return {H_in1, H_in0, M_in1, M_in0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_clock(input int h, input int m);
    H_out1 = 2'(h / 10);
    H_out0 = 4'(h % 10);
    M_out1 = 4'(m / 10);
    M_out0 = 4'(m % 10);
  endtask

  task automatic press_set();
    btn_set = 1'b1;
    @(negedge clk);
    btn_set = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
  endtask

  // SET rise in the minute edit, then capture the strobe word and width.
  task automatic commit_capture(output logic [15:0] obs, output int width);
    obs = '0;
    width = 0;
    btn_set = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn_set = 1'b0;
      if (LD_time || LD_alarm) begin
        if (width == 0) obs = obs_word();
        width++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    compared++;
    if (obs_word() !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h expected %h", obs_word(), 16'h0000);
    end
    compared++;
    if ({editing, field_sel, target_alarm} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_status: got %b expected 000", {editing, field_sel, target_alarm});
    end
  endtask

  task automatic test_time_set();
    logic [15:0] obs;
    int width;
    set_clock(12, 34);
    btn_alarm = 1'b0;
    model_h = 12;
    model_m = 34;
    press_set();
    compared++;
    if ({editing, field_sel, target_alarm} !== 3'b100) begin
      mismatched++;
      $display("FAIL time_entry_status: got %b expected 100", {editing, field_sel, target_alarm});
    end
    compared++;
    if (obs_digits() !== exp_digits(model_h, model_m)) begin
      mismatched++;
      $display("FAIL time_entry_digits: got %h expected %h", obs_digits(), exp_digits(model_h, model_m));
    end
    repeat (3) begin
      press_inc();
      model_h = (model_h + 1) % 24;
    end
    press_set();
    compared++;
    if ({editing, field_sel} !== 2'b11) begin
      mismatched++;
      $display("FAIL time_to_min: got %b expected 11", {editing, field_sel});
    end
    repeat (2) begin
      press_inc();
      model_m = (model_m + 1) % 60;
    end
    compared++;
    if (obs_digits() !== exp_digits(model_h, model_m)) begin
      mismatched++;
      $display("FAIL time_edit_digits: got %h expected %h", obs_digits(), exp_digits(model_h, model_m));
    end
    exp_q.push_back(exp_word(1'b1, 1'b0, model_h, model_m));
    commit_capture(obs, width);
    compared++;
    if (width !== 1) begin
      mismatched++;
      $display("FAIL time_strobe_width: got %0d expected 1", width);
    end
    compared++;
    if (obs !== exp_q.pop_front()) begin
      mismatched++;
      $display("FAIL time_strobe_word: got %h expected %h", obs, exp_word(1'b1, 1'b0, model_h, model_m));
    end
    compared++;
    if ({editing, obs_digits()} !== {1'b0, exp_digits(model_h, model_m)}) begin
      mismatched++;
      $display("FAIL time_idle_hold: got %b/%h expected 0/%h", editing, obs_digits(), exp_digits(model_h, model_m));
    end
  endtask

  task automatic test_alarm_set();
    logic [15:0] obs;
    int width;
    btn_alarm = 1'b1;
    press_set();
    btn_alarm = 1'b0;
    model_h = 0;
    model_m = 0;
    compared++;
    if ({target_alarm, obs_digits()} !== {1'b1, exp_digits(0, 0)}) begin
      mismatched++;
      $display("FAIL alarm_entry: got %b/%h expected 1/%h", target_alarm, obs_digits(), exp_digits(0, 0));
    end
    repeat (46) begin
      press_inc();
      model_h = (model_h + 1) % 24;
    end
    compared++;
    if (obs_digits() !== exp_digits(model_h, model_m)) begin
      mismatched++;
      $display("FAIL alarm_hour_wrap: got %h expected %h", obs_digits(), exp_digits(model_h, model_m));
    end
    press_set();
    exp_q.push_back(exp_word(1'b0, 1'b1, model_h, model_m));
    commit_capture(obs, width);
    compared++;
    if (width !== 1) begin
      mismatched++;
      $display("FAIL alarm_strobe_width: got %0d expected 1", width);
    end
    compared++;
    if (obs !== exp_q.pop_front()) begin
      mismatched++;
      $display("FAIL alarm_strobe_word: got %h expected %h", obs, exp_word(1'b0, 1'b1, model_h, model_m));
    end
    btn_alarm = 1'b1;
    press_set();
    btn_alarm = 1'b0;
    compared++;
    if ({target_alarm, obs_digits()} !== {1'b1, exp_digits(22, 0)}) begin
      mismatched++;
      $display("FAIL alarm_reentry_shadow: got %b/%h expected 1/%h", target_alarm, obs_digits(), exp_digits(22, 0));
    end
  endtask

  // Continues from the alarm edit left open by test_alarm_set.
  task automatic test_timeout();
    int s0;
    int k;
    bit left;
    press_inc();
    s0 = strobe_cnt;
    left = 1'b0;
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      @(negedge clk);
      if (!editing) begin
        left = 1'b1;
        break;
      end
    end
    @(negedge clk);
    compared++;
    if (!left || strobe_cnt !== s0) begin
      mismatched++;
      $display("FAIL alarm_timeout: left=%0d strobes got %0d expected %0d", left, strobe_cnt, s0);
    end
    btn_alarm = 1'b1;
    press_set();
    btn_alarm = 1'b0;
    compared++;
    if (obs_digits() !== exp_digits(22, 0)) begin
      mismatched++;
      $display("FAIL shadow_after_timeout: got %h expected %h", obs_digits(), exp_digits(22, 0));
    end
    s0 = strobe_cnt;
    k = 1;
    while (editing && k < TIMEOUT + 20) begin
      @(negedge clk);
      k++;
    end
    compared++;
    if (k !== TIMEOUT) begin
      mismatched++;
      $display("FAIL timeout_exact: got %0d edges expected %0d", k, TIMEOUT);
    end
    @(negedge clk);
    compared++;
    if ({editing, field_sel, strobe_cnt} !== {2'b00, s0}) begin
      mismatched++;
      $display("FAIL timeout_no_strobe: editing=%0d strobes got %0d expected %0d", editing, strobe_cnt, s0);
    end
  endtask

  task automatic test_bcd_wrap();
    logic [15:0] obs;
    int width;
    btn_alarm = 1'b0;
    set_clock(23, 58);
    model_h = 23;
    model_m = 58;
    press_set();
    press_inc();
    model_h = (model_h + 1) % 24;
    compared++;
    if (obs_digits() !== exp_digits(model_h, model_m)) begin
      mismatched++;
      $display("FAIL hour_23_wrap: got %h expected %h", obs_digits(), exp_digits(model_h, model_m));
    end
    press_set();
    for (int i = 0; i < 3; i++) begin
      press_inc();
      model_m = (model_m + 1) % 60;
      compared++;
      if (obs_digits() !== exp_digits(model_h, model_m) || M_in0 > 4'd9 || M_in1 > 4'd5 || H_in0 > 4'd9) begin
        mismatched++;
        $display("FAIL min_wrap_step%0d: got %h expected %h", i, obs_digits(), exp_digits(model_h, model_m));
      end
    end
    exp_q.push_back(exp_word(1'b1, 1'b0, model_h, model_m));
    commit_capture(obs, width);
    compared++;
    if (width !== 1 || obs !== exp_q.pop_front()) begin
      mismatched++;
      $display("FAIL wrap_commit: got %h width %0d expected %h width 1", obs, width, exp_word(1'b1, 1'b0, model_h, model_m));
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] obs;
    int width;
    set_clock(7, 15);
    model_h = 7;
    model_m = 15;
    press_set();
    btn_set = 1'b1;
    btn_inc = 1'b1;
    @(negedge clk);
    btn_set = 1'b0;
    btn_inc = 1'b0;
    @(negedge clk);
    compared++;
    if ({editing, field_sel, obs_digits()} !== {2'b11, exp_digits(model_h, model_m)}) begin
      mismatched++;
      $display("FAIL set_inc_same_cycle: got %b/%h expected 11/%h", {editing, field_sel}, obs_digits(), exp_digits(model_h, model_m));
    end
    press_inc();
    model_m = (model_m + 1) % 60;
    exp_q.push_back(exp_word(1'b1, 1'b0, model_h, model_m));
    commit_capture(obs, width);
    compared++;
    if (width !== 1 || obs !== exp_q.pop_front()) begin
      mismatched++;
      $display("FAIL simul_commit: got %h width %0d expected %h width 1", obs, width, exp_word(1'b1, 1'b0, model_h, model_m));
    end
  endtask

  task automatic test_reset_mid_edit();
    logic [15:0] obs;
    int width;
    int s0;
    btn_alarm = 1'b0;
    set_clock(9, 45);
    press_set();
    press_set();
    press_inc();
    s0 = strobe_cnt;
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if ({obs_word(), editing, field_sel, target_alarm} !== 19'h0) begin
      mismatched++;
      $display("FAIL reset_mid_edit: got %h expected 0", {obs_word(), editing, field_sel, target_alarm});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (strobe_cnt !== s0) begin
      mismatched++;
      $display("FAIL reset_no_strobe: got %0d expected %0d", strobe_cnt, s0);
    end
    btn_alarm = 1'b1;
    press_set();
    btn_alarm = 1'b0;
    compared++;
    if (obs_digits() !== exp_digits(0, 0)) begin
      mismatched++;
      $display("FAIL shadow_cleared: got %h expected %h", obs_digits(), exp_digits(0, 0));
    end
    press_set();
    exp_q.push_back(exp_word(1'b0, 1'b1, 0, 0));
    commit_capture(obs, width);
    compared++;
    if (width !== 1 || obs !== exp_q.pop_front()) begin
      mismatched++;
      $display("FAIL alarm_zero_commit: got %h width %0d expected %h width 1", obs, width, exp_word(1'b0, 1'b1, 0, 0));
    end
  endtask

  task automatic test_hold_inc();
    logic [15:0] obs;
    int width;
    btn_alarm = 1'b0;
    set_clock(0, 0);
    model_h = 0;
`ifdef AUTO_REPEAT_EN
    model_m = 6;
`else
    model_m = 1;
`endif
    press_set();
    press_set();
    btn_inc = 1'b1;
    repeat (HOLD + 4 * REP + 1) @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
    compared++;
    if (obs_digits() !== exp_digits(model_h, model_m)) begin
      mismatched++;
      $display("FAIL hold_inc: got %h expected %h", obs_digits(), exp_digits(model_h, model_m));
    end
    exp_q.push_back(exp_word(1'b1, 1'b0, model_h, model_m));
    commit_capture(obs, width);
    compared++;
    if (width !== 1 || obs !== exp_q.pop_front()) begin
      mismatched++;
      $display("FAIL hold_commit: got %h width %0d expected %h width 1", obs, width, exp_word(1'b1, 1'b0, model_h, model_m));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_time_set();
    test_alarm_set();
    test_timeout();
    test_bcd_wrap();
    test_simultaneous();
    test_reset_mid_edit();
    test_hold_inc();
    compared++;
    if (exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
